// File: rtl/ee354_matrix_readout.sv
// Walks the 8x8 entry store one entry at a time for the SSDs, or shows the determinant.
// Latency: a new entry appears on Disp 3 cycles after a Next/Prev/Show_Det pulse (request, capture, show).
// Backpressure: none. Pulses that arrive while a fetch is in flight are dropped, not queued.
//
// Ports:
//   Clk, Reset          system clock; synchronous active-high reset
//   Next, Prev          single-cycle step pulses (forward / backward, wrapping)
//   Show_Det            single-cycle pulse toggling the entry view and the determinant view
//   Det_Valid, Det      determinant from the core; Det is shown only while Det_Valid is high
//   Rd_En, Rd_Addr      read request to the entry store, Rd_Addr = {row, col}
//   Rd_Data             store data, valid one cycle after Rd_En
//   Disp                eight hex nibbles, Disp[31:28] -> SSD7 ... Disp[3:0] -> SSD0
//   Row, Col            coordinates of the current index
//   Mode_Det, Busy      determinant view active / fetch in flight
module ee354_matrix_readout #(
  parameter int N    = 8,
  parameter int DW   = 8,
  parameter int DETW = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Next,
  input  logic            Prev,
  input  logic            Show_Det,
  input  logic            Det_Valid,
  input  logic [DETW-1:0] Det,
  output logic            Rd_En,
  output logic [5:0]      Rd_Addr,
  input  logic [DW-1:0]   Rd_Data,
  output logic [31:0]     Disp,
  output logic [2:0]      Row,
  output logic [2:0]      Col,
  output logic            Mode_Det,
  output logic            Busy
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;
  localparam logic [1:0] S_DET  = 2'd3;

  localparam logic [5:0] LAST_IDX = 6'(N * N - 1);

  logic [1:0]  state;
  logic [5:0]  idx;
  logic [5:0]  idx_inc;
  logic [5:0]  idx_dec;
  logic [31:0] det_view;
  logic [31:0] entry_view;

  // Explicit wrap so a smaller N still cycles over its own index range.
  assign idx_inc = (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
  assign idx_dec = (idx == 6'd0) ? LAST_IDX : idx - 6'd1;

  // A core that is not in Done shows as all zeros rather than a partial result.
  assign det_view = Det_Valid ? 32'(Det) : 32'h0000_0000;

  // Row/col nibbles on SSD7/SSD6, blank middle byte, signed entry on the low four digits.
  assign entry_view = {1'b0, idx[5:3], 1'b0, idx[2:0], 8'h00,
                       {(16 - DW){Rd_Data[DW-1]}}, Rd_Data};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_REQ;
      idx   <= 6'd0;
      Disp  <= 32'h0000_0000;
    end else begin
      case (state)
        S_REQ: state <= S_CAP;
        S_CAP: begin
          Disp  <= entry_view;
          state <= S_SHOW;
        end
        S_SHOW: begin
          if (Show_Det) begin
            Disp  <= det_view;
            state <= S_DET;
          end else if (Next && !Prev) begin
            idx   <= idx_inc;
            state <= S_REQ;
          end else if (Prev && !Next) begin
            idx   <= idx_dec;
            state <= S_REQ;
          end
        end
        S_DET: begin
          // Leaving re-fetches the same entry since the store may have been rewritten meanwhile.
          if (Show_Det) begin
            state <= S_REQ;
          end else begin
            Disp <= det_view;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign Rd_En    = (state == S_REQ);
  assign Busy     = (state == S_REQ) || (state == S_CAP);
  assign Mode_Det = (state == S_DET);
  assign Rd_Addr  = idx;
  assign Row      = idx[5:3];
  assign Col      = idx[2:0];

endmodule

// File: tb/tb_ee354_matrix_readout.sv
module tb_ee354_matrix_readout;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Next = 1'b0;
  logic        Prev = 1'b0;
  logic        Show_Det = 1'b0;
  logic        Det_Valid = 1'b0;
  logic [31:0] Det = 32'h0;
  logic        Rd_En;
  logic [5:0]  Rd_Addr;
  logic [7:0]  Rd_Data;
  logic [31:0] Disp;
  logic [2:0]  Row;
  logic [2:0]  Col;
  logic        Mode_Det;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  // Reference view of the world: store contents, current linear index, expected display.
  logic [7:0]  mem [64];
  int          idx_m;
  logic [31:0] exp_disp;

  ee354_matrix_readout #(.N(8), .DW(8), .DETW(32)) dut (
    .Clk(Clk), .Reset(Reset), .Next(Next), .Prev(Prev), .Show_Det(Show_Det),
    .Det_Valid(Det_Valid), .Det(Det), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr),
    .Rd_Data(Rd_Data), .Disp(Disp), .Row(Row), .Col(Col),
    .Mode_Det(Mode_Det), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Entry store: data one cycle after a read strobe, junk otherwise.
  always @(posedge Clk) Rd_Data <= Rd_En ? mem[Rd_Addr] : 8'($urandom);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] entry_disp(input int i);
    int v;
    v = int'(mem[i]);
    if (v >= 128) v = v - 256;
    return 32'((i / 8) * (1 << 28) + (i % 8) * (1 << 24) + (v & 'hFFFF));
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One Next (dir>0) or Prev (dir<0) pulse in S_SHOW, checked over the 3-cycle fetch.
  task automatic do_move(input int dir);
    if (dir > 0) Next = 1'b1; else Prev = 1'b1;
    tick();
    Next = 1'b0; Prev = 1'b0;
    idx_m = (idx_m + dir + 64) % 64;
    total++;
    if (Rd_En !== 1'b1 || Rd_Addr !== 6'(idx_m) || Row !== 3'(idx_m / 8) || Col !== 3'(idx_m % 8)) begin
      bad++;
      $display("FAIL move_req: en=%b addr=%0d row=%0d col=%0d, required en=1 addr=%0d", Rd_En, Rd_Addr, Row, Col, idx_m);
    end
    total++;
    if (Disp !== exp_disp) begin
      bad++;
      $display("FAIL move_hold1: disp=%h, required %h", Disp, exp_disp);
    end
    tick();
    total++;
    if (Busy !== 1'b1 || Rd_En !== 1'b0 || Disp !== exp_disp) begin
      bad++;
      $display("FAIL move_cap: busy=%b en=%b disp=%h, required busy=1 en=0 disp=%h", Busy, Rd_En, Disp, exp_disp);
    end
    tick();
    exp_disp = entry_disp(idx_m);
    total++;
    if (Disp !== exp_disp || Busy !== 1'b0 || Mode_Det !== 1'b0) begin
      bad++;
      $display("FAIL move_show: disp=%h busy=%b mode=%b, required disp=%h busy=0 mode=0", Disp, Busy, Mode_Det, exp_disp);
    end
  endtask

  task automatic walk_to(input int target);
    while (idx_m != target) begin
      if (((target - idx_m + 64) % 64) <= 32) do_move(1); else do_move(-1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) mem[i] = (i / 8 == i % 8) ? 8'd1 : 8'd0;
    Reset = 1'b1;
    tick(); tick();
    total++;
    if (Rd_En !== 1'b1 || Busy !== 1'b1 || Mode_Det !== 1'b0 || Disp !== 32'h0 ||
        Rd_Addr !== 6'd0 || Row !== 3'd0 || Col !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: en=%b busy=%b mode=%b disp=%h addr=%0d, required 1 1 0 0 0", Rd_En, Busy, Mode_Det, Disp, Rd_Addr);
    end
    Reset = 1'b0;
    tick();
    total++;
    if (Busy !== 1'b1 || Rd_En !== 1'b0 || Disp !== 32'h0) begin
      bad++;
      $display("FAIL reset_cap: busy=%b en=%b disp=%h, required busy=1 en=0 disp=0", Busy, Rd_En, Disp);
    end
    tick();
    idx_m = 0;
    exp_disp = entry_disp(0);
    total++;
    if (Disp !== 32'h0000_0001 || Busy !== 1'b0 || Row !== 3'd0 || Col !== 3'd0) begin
      bad++;
      $display("FAIL reset_first: disp=%h busy=%b row=%0d col=%0d, required 00000001 0 0 0", Disp, Busy, Row, Col);
    end
  endtask

  task automatic test_step_wrap();
    do_move(1);
    total++;
    if (Disp !== 32'h0100_0000) begin
      bad++;
      $display("FAIL step_first: disp=%h, required 01000000", Disp);
    end
    for (int i = 0; i < 63; i++) do_move(1);
    total++;
    if (Disp !== 32'h0000_0001 || Rd_Addr !== 6'd0) begin
      bad++;
      $display("FAIL step_wrap: disp=%h addr=%0d, required 00000001 0", Disp, Rd_Addr);
    end
    do_move(-1);
    total++;
    if (Disp !== 32'h7700_0001 || Rd_Addr !== 6'o77) begin
      bad++;
      $display("FAIL prev_wrap: disp=%h addr=%0d, required 77000001 63", Disp, Rd_Addr);
    end
  endtask

  task automatic test_signed_entry();
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[21] = 8'hFD;
    walk_to(21);
    total++;
    if (Disp !== 32'h2500_FFFD) begin
      bad++;
      $display("FAIL signed_entry: disp=%h, required 2500FFFD", Disp);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: do_move(1);
        1: do_move(-1);
        2: begin
          Next = 1'b1; Prev = 1'b1;
          tick();
          Next = 1'b0; Prev = 1'b0;
          total++;
          if (Busy !== 1'b0 || Rd_Addr !== 6'(idx_m) || Disp !== exp_disp) begin
            bad++;
            $display("FAIL both_pulse: busy=%b addr=%0d disp=%h, required 0 %0d %h", Busy, Rd_Addr, Disp, idx_m, exp_disp);
          end
        end
        default: tick();
      endcase
    end
  endtask

  task automatic test_det();
    logic [31:0] d;
    Det_Valid = 1'b1; Det = 32'h0000_002A; Show_Det = 1'b1;
    tick();
    Show_Det = 1'b0;
    total++;
    if (Mode_Det !== 1'b1 || Disp !== 32'h0000_002A || Busy !== 1'b0 || Rd_En !== 1'b0) begin
      bad++;
      $display("FAIL det_enter: mode=%b disp=%h busy=%b, required 1 0000002A 0", Mode_Det, Disp, Busy);
    end
    d = $urandom;
    Det = d;
    tick();
    total++;
    if (Disp !== d) begin
      bad++;
      $display("FAIL det_track: disp=%h, required %h", Disp, d);
    end
    Det_Valid = 1'b0;
    tick();
    total++;
    if (Disp !== 32'h0) begin
      bad++;
      $display("FAIL det_invalid: disp=%h, required 00000000", Disp);
    end
    Next = 1'b1;
    tick();
    Next = 1'b0; Prev = 1'b1;
    tick();
    Prev = 1'b0;
    total++;
    if (Mode_Det !== 1'b1 || Busy !== 1'b0 || Rd_Addr !== 6'(idx_m)) begin
      bad++;
      $display("FAIL det_ignore_step: mode=%b busy=%b addr=%0d, required 1 0 %0d", Mode_Det, Busy, Rd_Addr, idx_m);
    end
    mem[idx_m] = 8'($urandom);
    Show_Det = 1'b1;
    tick();
    Show_Det = 1'b0;
    total++;
    if (Rd_En !== 1'b1 || Rd_Addr !== 6'(idx_m) || Mode_Det !== 1'b0) begin
      bad++;
      $display("FAIL det_exit_req: en=%b addr=%0d mode=%b, required 1 %0d 0", Rd_En, Rd_Addr, Mode_Det, idx_m);
    end
    tick(); tick();
    exp_disp = entry_disp(idx_m);
    total++;
    if (Disp !== exp_disp || Busy !== 1'b0) begin
      bad++;
      $display("FAIL det_refetch: disp=%h busy=%b, required %h 0", Disp, Busy, exp_disp);
    end
  endtask

  task automatic test_drop();
    Next = 1'b1;
    tick();
    tick();
    Next = 1'b0; Show_Det = 1'b1;
    tick();
    Show_Det = 1'b0;
    idx_m = (idx_m + 1) % 64;
    exp_disp = entry_disp(idx_m);
    total++;
    if (Mode_Det !== 1'b0 || Rd_Addr !== 6'(idx_m) || Disp !== exp_disp || Busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_busy: mode=%b addr=%0d disp=%h busy=%b, required 0 %0d %h 0", Mode_Det, Rd_Addr, Disp, Busy, idx_m, exp_disp);
    end
    tick();
    total++;
    if (Busy !== 1'b0 || Rd_Addr !== 6'(idx_m) || Mode_Det !== 1'b0) begin
      bad++;
      $display("FAIL drop_not_queued: busy=%b addr=%0d mode=%b, required 0 %0d 0", Busy, Rd_Addr, Mode_Det, idx_m);
    end
    Next = 1'b1; Prev = 1'b1;
    tick();
    Next = 1'b0; Prev = 1'b0;
    tick();
    total++;
    if (Busy !== 1'b0 || Rd_Addr !== 6'(idx_m) || Disp !== exp_disp) begin
      bad++;
      $display("FAIL drop_both: busy=%b addr=%0d disp=%h, required 0 %0d %h", Busy, Rd_Addr, Disp, idx_m, exp_disp);
    end
  endtask

  task automatic test_reset_midfetch();
    mem[9] = 8'h5A;
    walk_to(8);
    Next = 1'b1;
    tick();
    Next = 1'b0;
    tick();
    total++;
    if (Rd_Addr !== 6'd9 || Busy !== 1'b1 || Rd_En !== 1'b0) begin
      bad++;
      $display("FAIL midfetch_setup: addr=%0d busy=%b en=%b, required 9 1 0", Rd_Addr, Busy, Rd_En);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++;
    if (Rd_Addr !== 6'd0 || Disp !== 32'h0 || Rd_En !== 1'b1 || Busy !== 1'b1 || Mode_Det !== 1'b0) begin
      bad++;
      $display("FAIL midfetch_reset: addr=%0d disp=%h en=%b busy=%b, required 0 00000000 1 1", Rd_Addr, Disp, Rd_En, Busy);
    end
    tick(); tick();
    idx_m = 0;
    exp_disp = entry_disp(0);
    total++;
    if (Disp !== exp_disp || Busy !== 1'b0) begin
      bad++;
      $display("FAIL midfetch_refetch: disp=%h busy=%b, required %h 0", Disp, Busy, exp_disp);
    end
  endtask

  initial begin
    test_reset();
    test_step_wrap();
    test_signed_entry();
    test_back_to_back();
    test_det();
    test_drop();
    test_reset_midfetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ee354_matrix_readout.md
# ee354_matrix_readout

Read-side companion to the matrix load path of the determinant design. The load path deposits switch values into the 8x8 entry store. This block walks that store and presents its contents on the SSDs. Stepping is entry by entry, driven by debounced single-cycle button pulses. A second view shows the 32-bit determinant produced by the core. It sits between the entry store's read port, the determinant core and the SSD scan mux in the top level.

## Interface
Parameters:
- N, 8, matrix dimension; the linear index range is 0..N*N-1.
- DW, 8, entry width; entries are two's-complement signed.
- DETW, 32, determinant width.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- Next  in  1  single-cycle pulse; advance to the next entry.
- Prev  in  1  single-cycle pulse; go back to the previous entry.
- Show_Det  in  1  single-cycle pulse; toggle between entry view and determinant view.
- Det_Valid  in  1  determinant core is in its Done state.
- Det  in  DETW  determinant value from the core.
- Rd_En  out  1  read strobe to the entry store.
- Rd_Addr  out  6  {row[2:0], col[2:0]} of the entry being read.
- Rd_Data  in  DW  store data; valid one cycle after Rd_En.
- Disp  out  32  eight hex nibbles; Disp[31:28] drives SSD7 and Disp[3:0] drives SSD0.
- Row  out  3  row of the displayed entry.
- Col  out  3  column of the displayed entry.
- Mode_Det  out  1  high while in the determinant view.
- Busy  out  1  high while a fetch is in flight.

## Operation
- States:
  - S_REQ: issue a read.
  - S_CAP: capture the returned data.
  - S_SHOW: idle, displaying an entry.
  - S_DET: displaying the determinant.
- Moore outputs:
  - Rd_En=1 only in S_REQ.
  - Busy=1 in S_REQ and S_CAP.
  - Mode_Det=1 only in S_DET.
- Index register idx (6 bits) holds the linear index. Rd_Addr, Row and Col all come from idx: Row=idx[5:3], Col=idx[2:0].
- S_REQ -> S_CAP unconditionally.
- S_CAP -> S_SHOW, loading Disp as follows:
  - Disp[31:28]={1'b0,Row}
  - Disp[27:24]={1'b0,Col}
  - Disp[23:16]=0
  - Disp[15:0]=Rd_Data sign-extended to 16 bits
- In S_SHOW, priority is Show_Det > (Next xor Prev):
  - Show_Det -> S_DET.
  - Next alone: idx<=idx+1 (63 wraps to 0), go to S_REQ.
  - Prev alone: idx<=idx-1 (0 wraps to 63), go to S_REQ.
  - Next and Prev in the same cycle: no move, remain in S_SHOW.
- In S_DET:
  - Disp=Det when Det_Valid=1, else 32'h0000_0000. This is sampled every cycle, so it tracks the core.
  - Show_Det -> S_REQ at the unchanged idx. The entry is re-fetched because the store may have been rewritten.
  - Next and Prev are ignored.
- Next, Prev and Show_Det arriving in S_REQ or S_CAP are dropped, not queued.
- Reset state: S_REQ, idx=0, Disp=0, Row=0, Col=0, Mode_Det=0, Rd_En=1, Busy=1. Entry (0,0) is therefore auto-fetched out of reset.
- Reset asserted in any state, including mid-fetch, returns to the reset state on the next edge. Any in-flight Rd_Data is discarded.

## Timing
- Reset deasserted at cycle 0: cycle 0 is S_REQ with Rd_Addr=0; cycle 1 is S_CAP; Disp is valid and Busy=0 from cycle 2.
- Next/Prev pulse in S_SHOW at cycle t:
  - cycle t+1: S_REQ, Rd_Addr is the new index.
  - cycle t+2: S_CAP.
  - cycle t+3: new Disp.
  - Disp holds its old value through t+2.
- Show_Det at cycle t in S_SHOW: Mode_Det=1 and Disp=Det from cycle t+1.
- Show_Det at cycle t in S_DET: entry Disp returns at cycle t+3.
- Sustained step rate is one entry per 3 cycles; slower pulses are never lost.

## Test plan
- Identity store, reset released -> cycle 2: Disp=32'h0000_0001, Row=0, Col=0, Busy=0.
- One Next -> Disp=32'h0100_0000 three cycles later. 63 further Nexts -> idx wraps, Disp=32'h0000_0001.
- Prev at idx 0 -> Rd_Addr=6'o77, Disp=32'h7700_0001. Store entry (2,5)=8'hFD, navigate there -> Disp=32'h2500_FFFD.
- Show_Det with Det_Valid=1, Det=32'h0000_002A -> Mode_Det=1, Disp=32'h0000_002A. Det_Valid drops -> Disp=0. Show_Det again -> re-fetch at the same idx, entry shown 3 cycles later.
- Next in S_REQ, Show_Det in S_CAP, and Next+Prev together in S_SHOW -> all have no effect; idx unchanged.
- Reset asserted during S_CAP with idx=9 -> next cycle is S_REQ with Rd_Addr=0 and Disp=0; the stale data is not displayed.
